// File: rtl/adxl362_pkg.sv
// Shared definitions for the ADXL362 SPI responder.
// Holds the command opcodes, frame-state type, named register
// addresses, the soft-reset key and the power-on register defaults.
package adxl362_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
    localparam logic [7:0] ADDR_PARTID     = 8'h02;
    localparam logic [7:0] ADDR_XDATA      = 8'h08;
    localparam logic [7:0] ADDR_STATUS     = 8'h0B;
    localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
    localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;

    typedef enum logic [1:0] {
        ST_CMD    = 2'd0,
        ST_ADDR   = 2'd1,
        ST_DATA   = 2'd2,
        ST_IGNORE = 2'd3
    } state_t;

    function automatic logic [7:0] reg_default(input logic [7:0] a);
        logic [7:0] v;
        case (a)
            ADDR_DEVID_AD:   v = 8'hAD;
            ADDR_DEVID_MST:  v = 8'h1D;
            ADDR_PARTID:     v = 8'hF2;
            ADDR_FILTER_CTL: v = 8'h13;
            default:         v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adxl362_regmap.sv
// 64x8 register storage for the ADXL362 responder.
// Ports:
//   sclk_o, rst    clock and async active-high reset (loads defaults)
//   we/waddr/wdata single write port
//   soft_rst       synchronous reload of defaults (wins over a write)
//   raddr/rdata    asynchronous read port
module adxl362_regmap
    import adxl362_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              sclk_o,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              soft_rst,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sclk_o or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= reg_default(8'(i));
        end else if (soft_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= reg_default(8'(i));
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adxl362_spi_responder.sv
// SPI slave modelling the ADXL362 side of the link: cmd, addr, data bytes,
// MSB first, sampled on posedge sclk_o, with auto-incrementing bursts.
// Ports:
//   sclk_o, rst         SPI clock, async active-high reset
//   ncs_o, mosi_i       chip select (low = active), serial data in
//   miso_o              serial data out, high-Z while deselected
//   status_i, xdata_i   live values returned at STATUS / XDATA
//   reg_wr_o            one-period pulse per committed register write
//   reg_addr_o/data_o   address/data of the last committed write
//   cmd_err_o           sticky unknown-command flag
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_CMD    | collecting the command byte
// ST_ADDR   | collecting the start address
// ST_DATA   | burst transfer, address increments per byte
// ST_IGNORE | unknown command, bytes consumed until deselect
module adxl362_spi_responder
    import adxl362_pkg::*;
#(
    parameter int         ADDR_W = 6,
    parameter logic [7:0] WR_LO  = 8'h1F,
    parameter logic [7:0] WR_HI  = 8'h2E
) (
    input  logic              sclk_o,
    input  logic              rst,
    input  logic              ncs_o,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [7:0]        status_i,
    input  logic [7:0]        xdata_i,
    output logic              reg_wr_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_data_o,
    output logic              cmd_err_o
);

    state_t            state;
    logic              is_rd;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_shift;
    logic [7:0]        tx_shift;
    logic [ADDR_W-1:0] addr;
    logic              soft_rst_pend;

    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        map_rdata;
    logic [7:0]        rd_val;
    logic              wr_hit;

    assign rx_byte   = {rx_shift[6:0], mosi_i};
    assign byte_done = (bit_cnt == 3'd7);
    assign addr_nxt  = ADDR_W'(addr + 1'b1);

    // During ADDR the first read address is the byte arriving now; in a
    // read burst the next load is always the following location.
    assign rd_addr = (state == ST_ADDR) ? rx_byte[ADDR_W-1:0] : addr_nxt;

    assign rd_val = (8'(rd_addr) == ADDR_XDATA)  ? xdata_i  :
                    (8'(rd_addr) == ADDR_STATUS) ? status_i : map_rdata;

    assign wr_hit = !ncs_o && byte_done && (state == ST_DATA) && !is_rd &&
                    (8'(addr) >= WR_LO) && (8'(addr) <= WR_HI);

    adxl362_regmap #(.ADDR_W(ADDR_W)) u_regmap (
        .sclk_o   (sclk_o),
        .rst      (rst),
        .we       (wr_hit),
        .waddr    (addr),
        .wdata    (rx_byte),
        .soft_rst (soft_rst_pend),
        .raddr    (rd_addr),
        .rdata    (map_rdata)
    );

    // Frame-scoped state: cleared whenever the master deselects.
    always_ff @(posedge sclk_o or posedge rst or posedge ncs_o) begin
        if (rst || ncs_o) begin
            state    <= ST_CMD;
            is_rd    <= 1'b0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            reg_wr_o <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            reg_wr_o <= wr_hit;
            if (state == ST_DATA && is_rd) tx_shift <= {tx_shift[6:0], 1'b0};
            if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        if (rx_byte == CMD_WRITE) begin
                            state <= ST_ADDR;
                            is_rd <= 1'b0;
                        end else if (rx_byte == CMD_READ) begin
                            state <= ST_ADDR;
                            is_rd <= 1'b1;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_ADDR: begin
                        state <= ST_DATA;
                        if (is_rd) tx_shift <= rd_val;
                    end
                    ST_DATA: begin
                        if (is_rd) tx_shift <= rd_val;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State that survives deselect; only rst clears it.
    always_ff @(posedge sclk_o or posedge rst) begin
        if (rst) begin
            rx_shift      <= 8'h00;
            addr          <= '0;
            reg_addr_o    <= '0;
            reg_data_o    <= 8'h00;
            cmd_err_o     <= 1'b0;
            soft_rst_pend <= 1'b0;
        end else begin
            // Held outside the frame so the reload still lands if the
            // master deselects right after the key byte.
            soft_rst_pend <= wr_hit && (8'(addr) == ADDR_SOFT_RESET) &&
                             (rx_byte == SOFT_RESET_KEY);
            if (!ncs_o) begin
                rx_shift <= rx_byte;
                if (byte_done) begin
                    if (state == ST_CMD && rx_byte != CMD_WRITE && rx_byte != CMD_READ)
                        cmd_err_o <= 1'b1;
                    if (state == ST_ADDR) addr <= rx_byte[ADDR_W-1:0];
                    if (state == ST_DATA) addr <= addr_nxt;
                    if (wr_hit) begin
                        reg_addr_o <= addr;
                        reg_data_o <= rx_byte;
                    end
                end
            end
        end
    end

    assign miso_o = ncs_o ? 1'bz : tx_shift[7];

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Randomized bench for adxl362_spi_responder against an array-based model
// of the register map and burst rules.
module tb_adxl362_spi_responder;

    logic       sclk_o = 1'b0;
    logic       rst;
    logic       ncs_o;
    logic       mosi_i;
    logic       miso_o;
    logic [7:0] status_i;
    logic [7:0] xdata_i;
    logic       reg_wr_o;
    logic [5:0] reg_addr_o;
    logic [7:0] reg_data_o;
    logic       cmd_err_o;

    int total = 0;
    int bad   = 0;

    always #5 sclk_o = ~sclk_o;

    adxl362_spi_responder dut (
        .sclk_o     (sclk_o),
        .rst        (rst),
        .ncs_o      (ncs_o),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .status_i   (status_i),
        .xdata_i    (xdata_i),
        .reg_wr_o   (reg_wr_o),
        .reg_addr_o (reg_addr_o),
        .reg_data_o (reg_data_o),
        .cmd_err_o  (cmd_err_o)
    );

    logic [7:0]  model [64];
    logic        err_exp;
    logic [7:0]  tx_b  [12];
    logic [7:0]  rx_b  [12];
    logic [7:0]  wdat  [8];
    logic [13:0] wr_seen[$];
    logic [13:0] wr_exp[$];

    always @(negedge sclk_o) begin
        #1;
        if (reg_wr_o === 1'b1) wr_seen.push_back({reg_addr_o, reg_data_o});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_defaults();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        model[8'h00] = 8'hAD;
        model[8'h01] = 8'h1D;
        model[8'h02] = 8'hF2;
        model[8'h2C] = 8'h13;
    endfunction

    function automatic logic [7:0] model_rd(input int a);
        if (a == 8'h08) return xdata_i;
        if (a == 8'h0B) return status_i;
        return model[a];
    endfunction

    // Clocks nb full bytes plus 'extra' bits of tx_b out, capturing miso.
    task automatic shift_frame(input int nb, input int extra);
        int nbits;
        nbits = nb * 8 + extra;
        for (int k = 0; k < nbits; k++) begin
            @(negedge sclk_o);
            ncs_o  = 1'b0;
            mosi_i = tx_b[k / 8][7 - (k % 8)];
            #1;
            rx_b[k / 8][7 - (k % 8)] = miso_o;
        end
        @(negedge sclk_o);
        #2;
        ncs_o  = 1'b1;
        mosi_i = 1'b0;
        repeat (2) @(negedge sclk_o);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] a, input int nd, input int extra);
        logic [7:0] exp_rx [12];
        int ad;
        bit is_wr, is_rd;
        is_wr = (cmd == 8'h0A);
        is_rd = (cmd == 8'h0B);
        if (!is_wr && !is_rd) err_exp = 1'b1;
        tx_b[0] = cmd;
        tx_b[1] = a;
        for (int i = 0; i < nd; i++) tx_b[2 + i] = wdat[i];
        tx_b[2 + nd] = 8'($urandom);
        for (int i = 0; i < 12; i++) exp_rx[i] = 8'h00;
        wr_seen.delete();
        wr_exp.delete();
        ad = int'(a) % 64;
        for (int i = 0; i < nd; i++) begin
            if (is_rd) exp_rx[2 + i] = model_rd(ad);
            if (is_wr && ad >= 8'h1F && ad <= 8'h2E) begin
                model[ad] = wdat[i];
                wr_exp.push_back({6'(ad), wdat[i]});
                if (ad == 8'h1F && wdat[i] == 8'h52) model_defaults();
            end
            ad = (ad + 1) % 64;
        end
        shift_frame(2 + nd, extra);
        for (int i = 0; i < 2 + nd; i++) check($sformatf("rx[%0d] cmd=%0h a=%0h", i, cmd, a), rx_b[i], exp_rx[i]);
        check("wr_count", wr_seen.size(), wr_exp.size());
        for (int i = 0; i < wr_exp.size() && i < wr_seen.size(); i++)
            check("wr_addr_data", wr_seen[i], wr_exp[i]);
        check("cmd_err", cmd_err_o, err_exp);
    endtask

    initial begin
        rst      = 1'b1;
        ncs_o    = 1'b1;
        mosi_i   = 1'b0;
        status_i = 8'h00;
        xdata_i  = 8'h00;
        model_defaults();
        err_exp = 1'b0;
        repeat (3) @(negedge sclk_o);
        #1;
        check("rst reg_wr", reg_wr_o, 1'b0);
        check("rst reg_addr", reg_addr_o, 6'h00);
        check("rst reg_data", reg_data_o, 8'h00);
        check("rst cmd_err", cmd_err_o, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge sclk_o);

        // ID registers
        run_frame(8'h0B, 8'h00, 3, 0);
        // writable register round trip
        wdat[0] = 8'h55;
        run_frame(8'h0A, 8'h2C, 1, 0);
        run_frame(8'h0B, 8'h2C, 1, 0);
        check("2C after write", model[8'h2C], 8'h55);
        // read-only location ignores writes
        wdat[0] = 8'hFF;
        run_frame(8'h0A, 8'h00, 1, 0);
        run_frame(8'h0B, 8'h00, 1, 0);
        // wrap at top of map, live STATUS/XDATA
        status_i = 8'h41;
        xdata_i  = 8'h9C;
        run_frame(8'h0B, 8'h3E, 3, 0);
        run_frame(8'h0B, 8'h07, 5, 0);
        // soft reset
        wdat[0] = 8'h77;
        run_frame(8'h0A, 8'h2C, 1, 0);
        wdat[0] = 8'h52;
        run_frame(8'h0A, 8'h1F, 1, 0);
        run_frame(8'h0B, 8'h2C, 1, 0);
        run_frame(8'h0B, 8'h1F, 1, 0);
        // unknown command, then aborted partial frame
        run_frame(8'h0D, 8'h2C, 2, 0);
        tx_b[0] = 8'h0A;
        shift_frame(0, 4);
        run_frame(8'h0B, 8'h00, 1, 0);

        // randomized frames
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [7:0] cmd, a;
            r = $urandom_range(0, 9);
            if (r < 5)      cmd = 8'h0A;
            else if (r < 9) cmd = 8'h0B;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'hFF;
            end
            if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(8'h1B, 8'h32));
            else                           a = 8'($urandom);
            for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
            if ($urandom_range(0, 15) == 0) wdat[0] = 8'h52;
            status_i = 8'($urandom);
            xdata_i  = 8'($urandom);
            run_frame(cmd, a, $urandom_range(1, 6), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end

        // reset clears sticky error and restores defaults
        @(negedge sclk_o);
        rst = 1'b1;
        @(negedge sclk_o);
        #1;
        check("rst2 cmd_err", cmd_err_o, 1'b0);
        check("rst2 reg_wr", reg_wr_o, 1'b0);
        rst = 1'b0;
        model_defaults();
        err_exp = 1'b0;
        repeat (2) @(negedge sclk_o);
        run_frame(8'h0B, 8'h2C, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
